ls_buffer: RTL

- In-order load/store queue between the dispatcher and the load/store controller.
- Holds memory ops in program order and captures missing operands from the ALU and LS CDBs.
- Holds stores until the ROB commits them.
- Issues the head entry to the load/store controller, one op at a time, when that controller reports idle.

---
 rtl/ls_buffer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ls_buffer.sv
// In-order load/store queue. Entries wait here for their base/store-data
// operands (snooped from the ALU and LS CDBs) and, for stores, for the ROB
// commit. The head entry is handed to the load/store controller one op at a
// time. Opcode encoding: LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7.
module ls_buffer #(
    parameter int LSB_WIDTH  = 4,
    parameter int OP_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rdy_dsp_in,
    input  logic [OP_WIDTH-1:0]   opcode_dsp_in,
    input  logic [DATA_WIDTH-1:0] vj_dsp_in,
    input  logic [DATA_WIDTH-1:0] vk_dsp_in,
    input  logic [DATA_WIDTH-1:0] imm_dsp_in,
    input  logic [ROB_WIDTH-1:0]  qj_dsp_in,
    input  logic [ROB_WIDTH-1:0]  qk_dsp_in,
    input  logic                  jrdy_dsp_in,
    input  logic                  krdy_dsp_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_dsp_in,
    output logic                  full_lsb_out,
    input  logic                  rdy_alu_cdb_in,
    input  logic [DATA_WIDTH-1:0] result_alu_cdb_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_alu_cdb_in,
    input  logic                  rdy_ls_cdb_in,
    input  logic [DATA_WIDTH-1:0] result_ls_cdb_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_ls_cdb_in,
    input  logic                  commit_store_rob_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_commit_rob_in,
    input  logic                  refresh_rob_cdb_in,
    input  logic                  idle_lsc_in,
    output logic                  rdy_lsb_out,
    output logic [OP_WIDTH-1:0]   opcode_lsb_out,
    output logic [DATA_WIDTH-1:0] vj_lsb_out,
    output logic [DATA_WIDTH-1:0] vk_lsb_out,
    output logic [DATA_WIDTH-1:0] imm_lsb_out,
    output logic [ROB_WIDTH-1:0]  rob_id_lsb_out
);
    localparam int DEPTH = 1 << LSB_WIDTH;
    localparam logic [OP_WIDTH-1:0] OP_SB = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SH = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SW = OP_WIDTH'(7);

    function automatic logic is_store(input logic [OP_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    logic [LSB_WIDTH-1:0]  head_reg, tail_reg;
    logic [LSB_WIDTH:0]    count_reg, kept_count;
    logic [DEPTH-1:0]      busy_vec, jrdy_vec, krdy_vec, committed_vec;
    logic [OP_WIDTH-1:0]   opcode_arr [DEPTH];
    logic [DATA_WIDTH-1:0] vj_arr [DEPTH];
    logic [DATA_WIDTH-1:0] vk_arr [DEPTH];
    logic [DATA_WIDTH-1:0] imm_arr [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_arr [DEPTH];
    logic                  dispatch_fire, issue_fire;
    logic                  dsp_is_store, dsp_j_alu, dsp_j_ls, dsp_k_alu, dsp_k_ls;

    assign full_lsb_out  = (count_reg == (LSB_WIDTH+1)'(DEPTH));
    assign dispatch_fire = rdy_in && !refresh_rob_cdb_in && rdy_dsp_in && !full_lsb_out;
    // Issue decision uses only registered entry state; a same-cycle capture or
    // commit makes the head eligible on the following cycle.
    assign issue_fire    = rdy_in && !refresh_rob_cdb_in && busy_vec[head_reg] && jrdy_vec[head_reg]
                           && (!is_store(opcode_arr[head_reg])
                               || (krdy_vec[head_reg] && committed_vec[head_reg]))
                           && idle_lsc_in && !rdy_lsb_out;

    // A dispatching op can pick up a CDB value broadcast in the same cycle.
    assign dsp_is_store = is_store(opcode_dsp_in);
    assign dsp_j_alu    = rdy_alu_cdb_in && (rob_id_alu_cdb_in == qj_dsp_in);
    assign dsp_j_ls     = rdy_ls_cdb_in  && (rob_id_ls_cdb_in  == qj_dsp_in);
    assign dsp_k_alu    = rdy_alu_cdb_in && (rob_id_alu_cdb_in == qk_dsp_in);
    assign dsp_k_ls     = rdy_ls_cdb_in  && (rob_id_ls_cdb_in  == qk_dsp_in);

    // Committed stores form a contiguous run from head, so their number is
    // exactly how many entries survive a flush.
    always_comb begin
        kept_count = '0;
        for (int i = 0; i < DEPTH; i++)
            kept_count = kept_count + (LSB_WIDTH+1)'(busy_vec[i] & committed_vec[i]);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic                  busy_reg, jrdy_reg, krdy_reg, committed_reg;
            logic [OP_WIDTH-1:0]   opcode_reg;
            logic [DATA_WIDTH-1:0] vj_reg, vk_reg, imm_reg;
            logic [ROB_WIDTH-1:0]  qj_reg, qk_reg, rob_id_reg;
            logic                  write_en, issue_clr, j_alu, j_ls, k_alu, k_ls, commit_hit;

            assign write_en   = dispatch_fire && (tail_reg == LSB_WIDTH'(gi));
            assign issue_clr  = issue_fire && (head_reg == LSB_WIDTH'(gi));
            assign j_alu      = rdy_alu_cdb_in && (rob_id_alu_cdb_in == qj_reg);
            assign j_ls       = rdy_ls_cdb_in  && (rob_id_ls_cdb_in  == qj_reg);
            assign k_alu      = rdy_alu_cdb_in && (rob_id_alu_cdb_in == qk_reg);
            assign k_ls       = rdy_ls_cdb_in  && (rob_id_ls_cdb_in  == qk_reg);
            assign commit_hit = commit_store_rob_in && is_store(opcode_reg)
                                && (rob_id_reg == rob_id_commit_rob_in);

            assign busy_vec[gi]      = busy_reg;
            assign jrdy_vec[gi]      = jrdy_reg;
            assign krdy_vec[gi]      = krdy_reg;
            assign committed_vec[gi] = committed_reg;
            assign opcode_arr[gi]    = opcode_reg;
            assign vj_arr[gi]        = vj_reg;
            assign vk_arr[gi]        = vk_reg;
            assign imm_arr[gi]       = imm_reg;
            assign rob_arr[gi]       = rob_id_reg;

            // Entry lifecycle: fill on dispatch, snoop CDBs/commit while busy,
            // free on issue or on a flush unless it is a committed store.
            always_ff @(posedge clk_in) begin
                if (rst_in) begin
                    busy_reg <= 1'b0; jrdy_reg <= 1'b0; krdy_reg <= 1'b0; committed_reg <= 1'b0;
                    opcode_reg <= '0; vj_reg <= '0; vk_reg <= '0; imm_reg <= '0;
                    qj_reg <= '0; qk_reg <= '0; rob_id_reg <= '0;
                end else if (rdy_in) begin
                    if (refresh_rob_cdb_in) begin
                        if (!committed_reg) busy_reg <= 1'b0;
                    end else if (write_en) begin
                        busy_reg      <= 1'b1;
                        committed_reg <= 1'b0;
                        opcode_reg    <= opcode_dsp_in;
                        imm_reg       <= imm_dsp_in;
                        rob_id_reg    <= rob_id_dsp_in;
                        qj_reg        <= qj_dsp_in;
                        qk_reg        <= qk_dsp_in;
                        if (jrdy_dsp_in)    begin vj_reg <= vj_dsp_in;         jrdy_reg <= 1'b1; end
                        else if (dsp_j_alu) begin vj_reg <= result_alu_cdb_in; jrdy_reg <= 1'b1; end
                        else if (dsp_j_ls)  begin vj_reg <= result_ls_cdb_in;  jrdy_reg <= 1'b1; end
                        else                begin vj_reg <= vj_dsp_in;         jrdy_reg <= 1'b0; end
                        if (!dsp_is_store || krdy_dsp_in) begin vk_reg <= vk_dsp_in; krdy_reg <= 1'b1; end
                        else if (dsp_k_alu) begin vk_reg <= result_alu_cdb_in; krdy_reg <= 1'b1; end
                        else if (dsp_k_ls)  begin vk_reg <= result_ls_cdb_in;  krdy_reg <= 1'b1; end
                        else                begin vk_reg <= vk_dsp_in;         krdy_reg <= 1'b0; end
                    end else if (busy_reg) begin
                        if (issue_clr) begin
                            busy_reg      <= 1'b0;
                            committed_reg <= 1'b0;
                        end else begin
                            if (!jrdy_reg) begin
                                if (j_alu)     begin vj_reg <= result_alu_cdb_in; jrdy_reg <= 1'b1; end
                                else if (j_ls) begin vj_reg <= result_ls_cdb_in;  jrdy_reg <= 1'b1; end
                            end
                            if (!krdy_reg) begin
                                if (k_alu)     begin vk_reg <= result_alu_cdb_in; krdy_reg <= 1'b1; end
                                else if (k_ls) begin vk_reg <= result_ls_cdb_in;  krdy_reg <= 1'b1; end
                            end
                            if (commit_hit) committed_reg <= 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    // Queue pointers, occupancy and the registered issue port.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_reg <= '0; tail_reg <= '0; count_reg <= '0;
            rdy_lsb_out <= 1'b0; opcode_lsb_out <= '0; vj_lsb_out <= '0;
            vk_lsb_out <= '0; imm_lsb_out <= '0; rob_id_lsb_out <= '0;
        end else if (rdy_in) begin
            if (refresh_rob_cdb_in) begin
                tail_reg    <= head_reg + kept_count[LSB_WIDTH-1:0];
                count_reg   <= kept_count;
                rdy_lsb_out <= 1'b0;
            end else begin
                rdy_lsb_out <= issue_fire;
                if (issue_fire) begin
                    opcode_lsb_out <= opcode_arr[head_reg];
                    vj_lsb_out     <= vj_arr[head_reg];
                    vk_lsb_out     <= vk_arr[head_reg];
                    imm_lsb_out    <= imm_arr[head_reg];
                    rob_id_lsb_out <= rob_arr[head_reg];
                    head_reg       <= head_reg + 1'b1;
                end
                if (dispatch_fire) tail_reg <= tail_reg + 1'b1;
                if (dispatch_fire && !issue_fire)      count_reg <= count_reg + 1'b1;
                else if (!dispatch_fire && issue_fire) count_reg <= count_reg - 1'b1;
            end
        end
    end
endmodule
